mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Memory-side stage feeding the memory data register (MDR).
- Accepts single-word read/write commands from the control unit, using the address from MAR and write data from MDR.
- Drives a variable-latency RAM port with a ready handshake, and a wait-cycle timeout.
- On a read, returns the RAM word on mdr_data with a one-cycle mdr_load strobe. The MDR's memory-side input (selected when its select is low) loads it.

Parameters:
ADDR_W, 9, address width (512-word memory)
DATA_W, 32, data word width
TIMEOUT, 15, max wait cycles for mem_ready before abort; legal range 1..255

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-low reset
rd_req  in  1  read command, sampled only in IDLE
wr_req  in  1  write command, sampled only in IDLE
addr_in  in  ADDR_W  address from MAR
wdata_in  in  DATA_W  write data from MDR
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle error pulse (timeout or illegal command)
mem_addr  out  ADDR_W  registered RAM address
mem_wdata  out  DATA_W  registered RAM write data
mem_rd  out  1  RAM read strobe, held until accepted
mem_wr  out  1  RAM write strobe, held until accepted
mem_ready  in  1  RAM completion; read data valid on mem_rdata in the same cycle
mem_rdata  in  DATA_W  RAM read data
mdr_data  out  DATA_W  registered read result, connected to MDR memory input
mdr_load  out  1  one-cycle MDR enable pulse on read completion

Behaviour:
- Reset (clr low, asynchronous, any state):
  - State goes to IDLE.
  - All outputs are 0, including mdr_data, mem_addr and mem_wdata.
  - Timeout counter is cleared.
  - An in-flight access is abandoned, with no done or err pulse.
- States: IDLE, RD_WAIT, WR_WAIT, DONE, ERROR. All outputs are registered.
- IDLE:
  - rd_req=1, wr_req=0: latch addr_in into mem_addr, assert mem_rd, go to RD_WAIT.
  - wr_req=1, rd_req=0: latch addr_in and wdata_in, assert mem_wr, go to WR_WAIT.
  - Both high: illegal. Go to ERROR; no memory strobe is issued.
  - mem_ready is ignored in IDLE.
- RD_WAIT / WR_WAIT:
  - The strobe stays high, and mem_addr/mem_wdata stay stable, until mem_ready=1 is sampled.
  - The counter increments each wait cycle in which mem_ready=0.
- On mem_ready=1:
  - Drop the strobe and go to DONE.
  - In RD_WAIT, also capture mem_rdata into mdr_data.
- Timeout: if the counter reaches TIMEOUT with mem_ready=0, drop the strobe and go to ERROR.
  - mem_ready=1 in the terminal-count cycle wins: normal completion.
- DONE (one cycle):
  - done=1.
  - mdr_load=1 only if the access was a read.
  - Next state is IDLE.
- ERROR (one cycle): err=1, next state IDLE.
- mdr_data holds its value until the next read completes. Writes and errors never change mdr_data.
- Requests arriving while busy=1 are ignored, not queued. The control unit holds or re-issues them.
- Latency: request sampled at edge N; strobe high after N. If mem_ready is first sampled at edge N+1+k (k≥0), done and mdr_load are high during the cycle after that edge.
  - Minimum request-to-done is 2 cycles.
  - The earliest next request is accepted at the edge after done.
- Counter width is ceil(log2(TIMEOUT+1)). It never wraps; it clears on entry to any wait state.

Test Plan:
- Reset-then-read: hold clr low 3 cycles, release; rd_req with addr_in=0x05A; mem_ready high 1 cycle after mem_rd with mem_rdata=0xDEADBEEF. Required: mem_addr=0x05A, done and mdr_load high 1 cycle, mdr_data=0xDEADBEEF, busy low after.
- Write with 4-cycle wait: wr_req, addr_in=0x1FF, wdata_in=0x12345678. Required: mem_wr and mem_wdata stable for 4 wait cycles, then done high 1 cycle; mdr_load stays 0; mdr_data unchanged.
- Timeout: read with mem_ready never asserted, TIMEOUT=15. Required: mem_rd high exactly 15 cycles, err high 1 cycle, done never high, mdr_data unchanged. Repeat with mem_ready at the terminal cycle: required done, not err.
- Illegal command: rd_req=wr_req=1 in IDLE. Required: err pulse 1 cycle; mem_rd and mem_wr stay 0.
- Reset mid-access: assert clr low during RD_WAIT, asynchronously, mid-cycle. Required: all outputs 0 immediately, no done or err, and a new read after release completes normally.
- Back-to-back with busy drop: issue a second rd_req while busy; required to be ignored. Issue a read in the cycle after done; required accepted, done for each, and mdr_data updates to the second word (0x0000_0001 then 0xFFFF_FFFF).

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-side access controller: turns single-word read/write commands into a
// held-strobe RAM handshake with wait timeout, and returns read data to the MDR.
module mem_access_ctrl #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mdr_data,
    output logic              mdr_load
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Last wait cycle before the counter would hit TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_WAIT = 3'd1,
        S_WR_WAIT = 3'd2,
        S_DONE    = 3'd3,
        S_ERROR   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] mdr_data_q, mdr_data_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              mdr_load_q, mdr_load_d;

    // Next-state and next-output logic; pulses are computed on entry to DONE/ERROR.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mdr_data_d  = mdr_data_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mdr_load_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_req && !wr_req) begin
                    state_d    = S_RD_WAIT;
                    mem_addr_d = addr_in;
                    mem_rd_d   = 1'b1;
                    cnt_d      = '0;
                end else if (wr_req && !rd_req) begin
                    state_d     = S_WR_WAIT;
                    mem_addr_d  = addr_in;
                    mem_wdata_d = wdata_in;
                    mem_wr_d    = 1'b1;
                    cnt_d       = '0;
                end else if (rd_req && wr_req) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_WAIT, S_WR_WAIT: begin
                if (mem_ready) begin
                    state_d  = S_DONE;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    done_d   = 1'b1;
                    if (state_q == S_RD_WAIT) begin
                        mdr_data_d = mem_rdata;
                        mdr_load_d = 1'b1;
                    end else begin
                        mdr_load_d = 1'b0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = S_ERROR;
                    cnt_d    = cnt_q + CNT_ONE;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE, S_ERROR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered-output flops; clr abandons any access silently.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mdr_data_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mdr_load_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mdr_data_q  <= mdr_data_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mdr_load_q  <= mdr_load_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mdr_data  = mdr_data_q;
    assign mdr_load  = mdr_load_q;

endmodule
